// File: rtl/issue_stage_if.sv
// Bundles the upstream, regfile, writeback-snoop and downstream signals of issue_stage.
// slave is the issue stage's own view; master is the surrounding pipeline's view.
interface issue_stage_if #(
    parameter int unsigned CTRL_W = 32
);
    logic              flush;
    logic              id_valid;
    logic              id_ready;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [4:0]        id_rd;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic              id_rd_wen;
    logic [31:0]       id_pc;
    logic [CTRL_W-1:0] id_ctrl;
    logic [4:0]        rf_rs1;
    logic [4:0]        rf_rs2;
    logic              rf_rs1_valid;
    logic              rf_rs2_valid;
    logic [31:0]       rf_rs1_data;
    logic [31:0]       rf_rs2_data;
    logic [4:0]        rf_rd;
    logic              rf_reserve;
    logic              wb0_en;
    logic              wb1_en;
    logic [4:0]        wb0_reg;
    logic [4:0]        wb1_reg;
    logic [31:0]       wb0_data;
    logic [31:0]       wb1_data;
    logic              ex_valid;
    logic              ex_ready;
    logic [31:0]       ex_op1;
    logic [31:0]       ex_op2;
    logic [4:0]        ex_rd;
    logic              ex_rd_wen;
    logic [31:0]       ex_pc;
    logic [CTRL_W-1:0] ex_ctrl;

    modport slave (
        input  flush, id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_rd_wen,
               id_pc, id_ctrl, rf_rs1_valid, rf_rs2_valid, rf_rs1_data, rf_rs2_data,
               wb0_en, wb1_en, wb0_reg, wb1_reg, wb0_data, wb1_data, ex_ready,
        output id_ready, rf_rs1, rf_rs2, rf_rd, rf_reserve,
               ex_valid, ex_op1, ex_op2, ex_rd, ex_rd_wen, ex_pc, ex_ctrl
    );

    modport master (
        output flush, id_valid, id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2, id_rd_wen,
               id_pc, id_ctrl, rf_rs1_valid, rf_rs2_valid, rf_rs1_data, rf_rs2_data,
               wb0_en, wb1_en, wb0_reg, wb1_reg, wb0_data, wb1_data, ex_ready,
        input  id_ready, rf_rs1, rf_rs2, rf_rd, rf_reserve,
               ex_valid, ex_op1, ex_op2, ex_rd, ex_rd_wen, ex_pc, ex_ctrl
    );
endinterface

// File: rtl/issue_stage.sv
// Single-entry issue stage: holds one decoded instruction, waits for operands and a free
// destination (shadow busy vector, writeback bypass), then issues it to execute.
module issue_stage #(
    parameter int unsigned CTRL_W = 32
) (
    input logic          clk,
    input logic          reset,
    issue_stage_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, WAIT, OUT} state_e;

    state_e            state_q;
    logic [4:0]        h_rs1_q;
    logic [4:0]        h_rs2_q;
    logic [4:0]        h_rd_q;
    logic              h_use1_q;
    logic              h_use2_q;
    logic              h_wen_q;
    logic [31:0]       h_pc_q;
    logic [CTRL_W-1:0] h_ctrl_q;
    logic [31:0]       busy_q;
    logic [31:0]       busy_d;
    logic [31:0]       ex_op1_q;
    logic [31:0]       ex_op2_q;
    logic [4:0]        ex_rd_q;
    logic              ex_rd_wen_q;
    logic [31:0]       ex_pc_q;
    logic [CTRL_W-1:0] ex_ctrl_q;

    logic        id_ready_w;
    logic        accept;
    logic        hit0_1, hit1_1, hit0_2, hit1_2;
    logic        rdy1, rdy2;
    logic        rd_live;
    logic        waw_ok;
    logic        issue;
    logic        reserve;
    logic [31:0] op1, op2;

    assign id_ready_w = !reset && !bus.flush &&
                        ((state_q == EMPTY) || ((state_q == OUT) && bus.ex_ready));
    assign accept     = bus.id_valid && id_ready_w;

    always_comb begin
        hit0_1  = bus.wb0_en && (bus.wb0_reg == h_rs1_q) && (h_rs1_q != '0);
        hit1_1  = bus.wb1_en && (bus.wb1_reg == h_rs1_q) && (h_rs1_q != '0);
        hit0_2  = bus.wb0_en && (bus.wb0_reg == h_rs2_q) && (h_rs2_q != '0);
        hit1_2  = bus.wb1_en && (bus.wb1_reg == h_rs2_q) && (h_rs2_q != '0);

        if (h_rs1_q == '0)  op1 = '0;
        else if (hit0_1)    op1 = bus.wb0_data;
        else if (hit1_1)    op1 = bus.wb1_data;
        else                op1 = bus.rf_rs1_data;

        if (h_rs2_q == '0)  op2 = '0;
        else if (hit0_2)    op2 = bus.wb0_data;
        else if (hit1_2)    op2 = bus.wb1_data;
        else                op2 = bus.rf_rs2_data;

        rdy1    = !h_use1_q || (h_rs1_q == '0) || bus.rf_rs1_valid || hit0_1 || hit1_1;
        rdy2    = !h_use2_q || (h_rs2_q == '0) || bus.rf_rs2_valid || hit0_2 || hit1_2;
        rd_live = h_wen_q && (h_rd_q != '0);
        // A writeback to rd this cycle would race the reservation in the regfile, so wait it out.
        waw_ok  = !rd_live ||
                  (!busy_q[h_rd_q] &&
                   !(bus.wb0_en && (bus.wb0_reg == h_rd_q)) &&
                   !(bus.wb1_en && (bus.wb1_reg == h_rd_q)));
        issue   = (state_q == WAIT) && !reset && !bus.flush && rdy1 && rdy2 && waw_ok;
        reserve = issue && rd_live;

        busy_d = busy_q;
        if (reserve)    busy_d[h_rd_q]      = 1'b1;
        if (bus.wb0_en) busy_d[bus.wb0_reg] = 1'b0;
        if (bus.wb1_en) busy_d[bus.wb1_reg] = 1'b0;
        busy_d[0] = 1'b0;
    end

    assign bus.id_ready   = id_ready_w;
    assign bus.rf_rs1     = h_rs1_q;
    assign bus.rf_rs2     = h_rs2_q;
    assign bus.rf_reserve = reserve;
    assign bus.rf_rd      = reserve ? h_rd_q : '0;
    assign bus.ex_valid   = (state_q == OUT);
    assign bus.ex_op1     = ex_op1_q;
    assign bus.ex_op2     = ex_op2_q;
    assign bus.ex_rd      = ex_rd_q;
    assign bus.ex_rd_wen  = ex_rd_wen_q;
    assign bus.ex_pc      = ex_pc_q;
    assign bus.ex_ctrl    = ex_ctrl_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            h_rs1_q     <= '0;
            h_rs2_q     <= '0;
            h_rd_q      <= '0;
            h_use1_q    <= 1'b0;
            h_use2_q    <= 1'b0;
            h_wen_q     <= 1'b0;
            h_pc_q      <= '0;
            h_ctrl_q    <= '0;
            busy_q      <= '0;
            ex_op1_q    <= '0;
            ex_op2_q    <= '0;
            ex_rd_q     <= '0;
            ex_rd_wen_q <= 1'b0;
            ex_pc_q     <= '0;
            ex_ctrl_q   <= '0;
        end else begin
            busy_q <= busy_d;
            // accept is only possible from EMPTY or a draining OUT, so loading here never clobbers a live hold.
            if (accept) begin
                h_rs1_q  <= bus.id_rs1;
                h_rs2_q  <= bus.id_rs2;
                h_rd_q   <= bus.id_rd;
                h_use1_q <= bus.id_use_rs1;
                h_use2_q <= bus.id_use_rs2;
                h_wen_q  <= bus.id_rd_wen;
                h_pc_q   <= bus.id_pc;
                h_ctrl_q <= bus.id_ctrl;
            end
            if (bus.flush) begin
                state_q <= EMPTY;
            end else begin
                case (state_q)
                    EMPTY: if (accept) state_q <= WAIT;
                    WAIT: begin
                        if (issue) begin
                            state_q     <= OUT;
                            ex_op1_q    <= op1;
                            ex_op2_q    <= op2;
                            ex_rd_q     <= h_rd_q;
                            ex_rd_wen_q <= h_wen_q;
                            ex_pc_q     <= h_pc_q;
                            ex_ctrl_q   <= h_ctrl_q;
                        end
                    end
                    OUT: if (bus.ex_ready) state_q <= accept ? WAIT : EMPTY;
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_issue_stage.sv
// Directed scenarios plus randomized traffic for issue_stage, checked every cycle against
// a transaction-level reference model of the held slot, the issued slot and the busy table.
module tb_issue_stage;
    localparam int unsigned CW = 32;

    logic clk = 1'b0;
    logic reset;

    issue_stage_if #(.CTRL_W(CW)) bus ();
    issue_stage #(.CTRL_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    rs1, rs2, rd;
        logic          u1, u2, wen;
        logic [31:0]   pc;
        logic [CW-1:0] ctrl;
    } instr_t;

    instr_t        h;
    bit            m_held, m_out;
    bit            busy [32];
    logic [31:0]   m_op1, m_op2, m_pc;
    logic [4:0]    m_rd;
    logic          m_wen;
    logic [CW-1:0] m_ctrl;

    bit          e_ready, e_issue, e_res;
    logic [31:0] e_op1, e_op2;
    logic        obs_res, obs_rdy;
    logic [4:0]  obs_rd;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {ready, value} of one source operand under the current writeback snoop.
    function automatic logic [32:0] operand(input logic [4:0] rs, input logic use_rs,
                                            input logic rfv, input logic [31:0] rfd);
        logic h0, h1;
        logic [31:0] v;
        h0 = bus.wb0_en && bus.wb0_reg == rs && rs != 0;
        h1 = bus.wb1_en && bus.wb1_reg == rs && rs != 0;
        v  = (rs == 0) ? 32'd0 : h0 ? bus.wb0_data : h1 ? bus.wb1_data : rfd;
        return {(!use_rs || rs == 0 || rfv || h0 || h1), v};
    endfunction

    task automatic model_comb();
        logic [32:0] a, b;
        bit dest, clash;
        e_ready = !reset && !bus.flush && ((!m_held && !m_out) || (m_out && bus.ex_ready));
        a = operand(h.rs1, h.u1, bus.rf_rs1_valid, bus.rf_rs1_data);
        b = operand(h.rs2, h.u2, bus.rf_rs2_valid, bus.rf_rs2_data);
        e_op1 = a[31:0];
        e_op2 = b[31:0];
        dest  = h.wen && h.rd != 0;
        clash = dest && (busy[h.rd] || (bus.wb0_en && bus.wb0_reg == h.rd) ||
                         (bus.wb1_en && bus.wb1_reg == h.rd));
        e_issue = m_held && !reset && !bus.flush && a[32] && b[32] && !clash;
        e_res   = e_issue && dest;
    endtask

    task automatic model_edge();
        bit acc;
        if (reset) begin
            m_held = 0; m_out = 0;
            h = '{default: '0};
            foreach (busy[i]) busy[i] = 0;
            m_op1 = 0; m_op2 = 0; m_pc = 0; m_rd = 0; m_wen = 0; m_ctrl = 0;
            return;
        end
        acc = bus.id_valid && e_ready;
        if (e_res) busy[h.rd] = 1;
        if (bus.wb0_en) busy[bus.wb0_reg] = 0;
        if (bus.wb1_en) busy[bus.wb1_reg] = 0;
        busy[0] = 0;
        if (acc) h = '{bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_use_rs1, bus.id_use_rs2,
                      bus.id_rd_wen, bus.id_pc, bus.id_ctrl};
        if (bus.flush) begin
            m_held = 0; m_out = 0;
        end else if (e_issue) begin
            m_op1 = e_op1; m_op2 = e_op2; m_rd = h.rd; m_wen = h.wen; m_pc = h.pc; m_ctrl = h.ctrl;
            m_held = 0; m_out = 1;
        end else begin
            if (m_out && bus.ex_ready) m_out = 0;
            if (acc) m_held = 1;
        end
    endtask

    // Inputs are already driven (at a falling edge); run one full clock and check everything.
    task automatic step();
        #1;
        model_comb();
        obs_res = bus.rf_reserve;
        obs_rd  = bus.rf_rd;
        obs_rdy = bus.id_ready;
        check("id_ready", bus.id_ready, e_ready);
        check("rf_reserve", bus.rf_reserve, e_res);
        check("rf_rd", bus.rf_rd, e_res ? h.rd : 5'd0);
        if (m_held) begin
            check("rf_rs1", bus.rf_rs1, h.rs1);
            check("rf_rs2", bus.rf_rs2, h.rs2);
        end
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("ex_valid", bus.ex_valid, m_out);
        check("ex_op1", bus.ex_op1, m_op1);
        check("ex_op2", bus.ex_op2, m_op2);
        check("ex_rd", bus.ex_rd, m_rd);
        check("ex_rd_wen", bus.ex_rd_wen, m_wen);
        check("ex_pc", bus.ex_pc, m_pc);
        check("ex_ctrl", bus.ex_ctrl, m_ctrl);
    endtask

    task automatic idle();
        reset = 0; bus.flush = 0; bus.id_valid = 0;
        bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
        bus.id_use_rs1 = 0; bus.id_use_rs2 = 0; bus.id_rd_wen = 0;
        bus.id_pc = 0; bus.id_ctrl = 0;
        bus.rf_rs1_valid = 1; bus.rf_rs2_valid = 1; bus.rf_rs1_data = 0; bus.rf_rs2_data = 0;
        bus.wb0_en = 0; bus.wb1_en = 0; bus.wb0_reg = 0; bus.wb1_reg = 0;
        bus.wb0_data = 0; bus.wb1_data = 0; bus.ex_ready = 1;
    endtask

    task automatic put(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic u1, input logic u2, input logic wen);
        bus.id_valid = 1; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.id_rd = rd;
        bus.id_use_rs1 = u1; bus.id_use_rs2 = u2; bus.id_rd_wen = wen;
        bus.id_pc = $urandom; bus.id_ctrl = $urandom;
    endtask

    initial begin
        idle();
        @(negedge clk);
        reset = 1; step(); step();
        check("rst_ex_valid", bus.ex_valid, 0);
        check("rst_idready", obs_rdy, 0);
        reset = 0;

        // Basic issue with both operands from the regfile.
        put(1, 2, 3, 1, 1, 1); bus.rf_rs1_data = 32'h11; bus.rf_rs2_data = 32'h22;
        step();
        bus.id_valid = 0; step();
        check("s1_reserve", obs_res, 1);
        check("s1_rf_rd", obs_rd, 3);
        check("s1_exv", bus.ex_valid, 1);
        check("s1_op1", bus.ex_op1, 32'h11);
        check("s1_op2", bus.ex_op2, 32'h22);
        bus.wb0_en = 1; bus.wb0_reg = 3; step();
        check("s1_drain", bus.ex_valid, 0);

        // Operand via wb1 bypass, then wb0-over-wb1 priority.
        idle(); put(5, 0, 0, 1, 0, 0); bus.rf_rs1_valid = 0; step();
        bus.id_valid = 0; step();
        check("s2_stall", bus.ex_valid, 0);
        bus.wb1_en = 1; bus.wb1_reg = 5; bus.wb1_data = 32'hA5; step();
        check("s2_exv", bus.ex_valid, 1);
        check("s2_bypass", bus.ex_op1, 32'hA5);
        bus.wb1_en = 0; step();
        put(5, 0, 0, 1, 0, 0); step();
        bus.id_valid = 0;
        bus.wb0_en = 1; bus.wb0_reg = 5; bus.wb0_data = 32'h1;
        bus.wb1_en = 1; bus.wb1_reg = 5; bus.wb1_data = 32'h2;
        step();
        check("s2_prio", bus.ex_op1, 32'h1);
        bus.wb0_en = 0; bus.wb1_en = 0; step();

        // WAW stall on x7 until after its writeback.
        idle(); put(1, 2, 7, 1, 1, 1); step();
        bus.id_valid = 0; step();
        put(3, 4, 7, 1, 1, 1); step();
        bus.id_valid = 0; step();
        check("s3_stall_res", obs_res, 0);
        check("s3_stall_exv", bus.ex_valid, 0);
        step();
        bus.wb1_en = 1; bus.wb1_reg = 7; step();
        check("s3_wb_res", obs_res, 0);
        check("s3_wb_exv", bus.ex_valid, 0);
        bus.wb1_en = 0; step();
        check("s3_go_res", obs_res, 1);
        check("s3_go_rd", obs_rd, 7);
        check("s3_go_exv", bus.ex_valid, 1);
        bus.wb0_en = 1; bus.wb0_reg = 7; step();

        // Reserve/writeback collision on x4 defers issue one cycle.
        idle(); put(1, 2, 4, 1, 1, 1); step();
        bus.id_valid = 0; bus.wb0_en = 1; bus.wb0_reg = 4; step();
        check("s4_defer_res", obs_res, 0);
        check("s4_defer_exv", bus.ex_valid, 0);
        bus.wb0_en = 0; step();
        check("s4_res", obs_res, 1);
        check("s4_rd", obs_rd, 4);
        bus.wb0_en = 1; bus.wb0_reg = 4; step();

        // Downstream backpressure, flush in WAIT, x0 operand.
        idle(); put(1, 2, 0, 1, 1, 0); bus.rf_rs1_data = 32'h77; step();
        bus.id_valid = 0; step();
        bus.ex_ready = 0; put(9, 9, 9, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("s5_bp_idready", obs_rdy, 0);
            check("s5_bp_exv", bus.ex_valid, 1);
            check("s5_bp_op1", bus.ex_op1, 32'h77);
        end
        bus.id_valid = 0; bus.ex_ready = 1; step();
        put(1, 2, 6, 1, 1, 1); step();
        bus.id_valid = 0; bus.flush = 1; step();
        check("s5_flush_res", obs_res, 0);
        check("s5_flush_exv", bus.ex_valid, 0);
        bus.flush = 0; step();
        check("s5_flush_empty", obs_rdy, 1);
        put(0, 2, 0, 1, 1, 0); bus.rf_rs1_valid = 0; bus.rf_rs1_data = 32'hDEAD; step();
        bus.id_valid = 0; step();
        check("s5_x0_exv", bus.ex_valid, 1);
        check("s5_x0_op1", bus.ex_op1, 0);
        step();

        // Randomized traffic with small register numbers to provoke hazards.
        for (int n = 0; n < 3000; n++) begin
            reset            = ($urandom_range(99) == 0);
            bus.flush        = ($urandom_range(31) == 0);
            bus.id_valid     = $urandom_range(1);
            bus.id_rs1       = 5'($urandom_range(7));
            bus.id_rs2       = 5'($urandom_range(7));
            bus.id_rd        = 5'($urandom_range(7));
            bus.id_use_rs1   = ($urandom_range(4) != 0);
            bus.id_use_rs2   = ($urandom_range(4) != 0);
            bus.id_rd_wen    = ($urandom_range(9) < 7);
            bus.id_pc        = $urandom;
            bus.id_ctrl      = $urandom;
            bus.rf_rs1_valid = ($urandom_range(9) < 6);
            bus.rf_rs2_valid = ($urandom_range(9) < 6);
            bus.rf_rs1_data  = $urandom;
            bus.rf_rs2_data  = $urandom;
            bus.wb0_en       = ($urandom_range(9) < 3);
            bus.wb1_en       = ($urandom_range(9) < 3);
            bus.wb0_reg      = 5'($urandom_range(7));
            bus.wb1_reg      = 5'($urandom_range(7));
            bus.wb0_data     = $urandom;
            bus.wb1_data     = $urandom;
            bus.ex_ready     = ($urandom_range(9) < 7);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
